lfsr_prbs_check: RTL and testbench

- Receive-side PRBS checker, the counterpart to the team's parallel PRBS generator.
- Takes OUTPUT_WIDTH-bit words from a PRBS source and self-seeds its LFSR state from the received stream.
- Acquires lock, then predicts every following word independently of the input and counts bit errors.
- Used in link BIST and loopback test paths. Fibonacci configuration only.

---
 rtl/lfsr_prbs_check.sv | 222 ++++++++++++++++++++++
 tb/tb_lfsr_prbs_check.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_prbs_check.sv
`default_nettype none
// =============================================================================
// Module   : lfsr_prbs_check
// Purpose  : Receive-side PRBS checker for a parallel Fibonacci LFSR source.
//            Self-seeds its LFSR from the received stream, declares lock after
//            a run of clean words, then free-runs its own prediction and counts
//            mismatched bits and checked words.
// Ports    : clk         - clock, all logic on the rising edge
//            rst_n       - synchronous active-low reset
//            clear       - zero err_count and word_count (lock unaffected)
//            data_in     - received word, DATA_WIDTH bits
//            data_valid  - data_in is valid this cycle
//            locked      - checker is locked to the stream
//            error       - previous valid word had a mismatch while locked
//            err_count   - saturating count of mismatched bits while locked
//            word_count  - saturating count of words checked while locked
// Mapping  : state bit i holds the bit generated i+1 steps ago. LFSR_POLY bit k
//            taps the bit generated LFSR_WIDTH-k steps ago (x^LFSR_WIDTH is
//            implied). The first generated bit of a word lands in
//            data[DATA_WIDTH-1] when REVERSE=0 and in data[0] when REVERSE=1.
// Revision : 1.0 - initial release
// =============================================================================
module lfsr_prbs_check #(
  parameter int                    LFSR_WIDTH      = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY       = 31'h10000001,
  parameter int                    REVERSE         = 0,
  parameter int                    DATA_WIDTH      = 8,
  parameter int                    LOCK_COUNT      = 4,
  parameter int                    UNLOCK_COUNT    = 4,
  parameter int                    ERR_COUNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       data_valid,
  output logic                       locked,
  output logic                       error,
  output logic [ERR_COUNT_WIDTH-1:0] err_count,
  output logic [ERR_COUNT_WIDTH-1:0] word_count
);

  // Words needed before the seed register holds LFSR_WIDTH received bits.
  localparam int FILL   = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int FILL_W = $clog2(FILL + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
  localparam int POP_W  = $clog2(DATA_WIDTH + 1);
  localparam int SUM_W  = ERR_COUNT_WIDTH + 1;

  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(FILL);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_COUNT - 1);

  // Polynomial coefficient k multiplies state bit LFSR_WIDTH-1-k.
  function automatic logic [LFSR_WIDTH-1:0] tap_mask(input logic [LFSR_WIDTH-1:0] poly);
    logic [LFSR_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < LFSR_WIDTH; k++) begin
      m[LFSR_WIDTH-1-k] = poly[k];
    end
    return m;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] TAP_MASK = tap_mask(LFSR_POLY);

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                     state_q, state_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [GOOD_W-1:0]          good_q, good_d;
  logic [BAD_W-1:0]           bad_q, bad_d;
  logic [LFSR_WIDTH-1:0]      lfsr_q, lfsr_d;
  logic                       error_q, error_d;
  logic [ERR_COUNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [ERR_COUNT_WIDTH-1:0] word_count_q, word_count_d;

  logic [LFSR_WIDTH-1:0]      pred_state;
  logic [LFSR_WIDTH-1:0]      seed_state;
  logic [DATA_WIDTH-1:0]      pred_word;
  logic [DATA_WIDTH-1:0]      mismatch;
  logic [POP_W-1:0]           popcnt;
  logic [SUM_W-1:0]           err_sum;
  logic                       match;

  // Unrolled predictor: DATA_WIDTH Fibonacci steps from the current state.
  always_comb begin : p_predict
    logic fb;
    fb         = 1'b0;
    pred_state = lfsr_q;
    pred_word  = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb         = ^(pred_state & TAP_MASK);
      pred_state = (pred_state << 1) | LFSR_WIDTH'(fb);
      if (REVERSE != 0) begin
        pred_word = (pred_word >> 1) | (DATA_WIDTH'(fb) << (DATA_WIDTH - 1));
      end else begin
        pred_word = (pred_word << 1) | DATA_WIDTH'(fb);
      end
    end
  end

  // Seed path: shift the received bits in transmission order.
  always_comb begin : p_seed
    logic [DATA_WIDTH-1:0] rx;
    logic                  rx_bit;
    rx         = data_in;
    rx_bit     = 1'b0;
    seed_state = lfsr_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (REVERSE != 0) begin
        rx_bit = rx[0];
        rx     = rx >> 1;
      end else begin
        rx_bit = rx[DATA_WIDTH-1];
        rx     = rx << 1;
      end
      seed_state = (seed_state << 1) | LFSR_WIDTH'(rx_bit);
    end
  end

  assign mismatch = data_in ^ pred_word;

  always_comb begin : p_popcount
    popcnt = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      popcnt = popcnt + POP_W'(mismatch[i]);
    end
  end

  assign err_sum = {1'b0, err_count_q} + SUM_W'(popcnt);

  // An all-zero seed predicts all zeros forever; it must never count as a match.
  assign match = (mismatch == '0) && (lfsr_q != '0);

  always_comb begin : p_next
    state_d      = state_q;
    fill_d       = fill_q;
    good_d       = good_q;
    bad_d        = bad_q;
    lfsr_d       = lfsr_q;
    error_d      = 1'b0;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;

    if (data_valid) begin
      if (state_q == ST_HUNT) begin
        lfsr_d = seed_state;
        if (fill_q != FILL_DONE) begin
          fill_d = fill_q + FILL_W'(1);
        end else if (match) begin
          if (good_q == GOOD_LAST) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else begin
          good_d = '0;
        end
      end else begin
        // Free-run on the prediction so a bad word cannot corrupt the state.
        lfsr_d  = pred_state;
        error_d = (mismatch != '0);
        if (word_count_q != '1) begin
          word_count_d = word_count_q + ERR_COUNT_WIDTH'(1);
        end
        err_count_d = err_sum[SUM_W-1] ? '1 : err_sum[ERR_COUNT_WIDTH-1:0];
        if (mismatch != '0) begin
          if (bad_q == BAD_LAST) begin
            state_d = ST_HUNT;
            fill_d  = '0;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_q + BAD_W'(1);
          end
        end else begin
          bad_d = '0;
        end
      end
    end

    if (clear) begin
      err_count_d  = '0;
      word_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      fill_q       <= '0;
      good_q       <= '0;
      bad_q        <= '0;
      lfsr_q       <= '1;
      error_q      <= 1'b0;
      err_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      lfsr_q       <= lfsr_d;
      error_q      <= error_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign error      = error_q;
  assign err_count  = err_count_q;
  assign word_count = word_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_check.sv
`default_nettype none
// =============================================================================
// Module   : tb_lfsr_prbs_check
// Purpose  : Self-checking bench for lfsr_prbs_check. A bit-level PRBS source
//            and a sequence-level reference checker drive the comparisons; a
//            second instance with 4-bit counters exercises saturation.
// Revision : 1.0 - initial release
// =============================================================================
module tb_lfsr_prbs_check;

  localparam int          W       = 31;
  localparam logic [30:0] POLY    = 31'h10000001;
  localparam int          DW      = 8;
  localparam int          LOCKN   = 4;
  localparam int          UNLOCKN = 4;
  localparam int          FILLN   = (W + DW - 1) / DW;
  localparam longint      MAX32   = 64'hFFFF_FFFF;
  localparam longint      MAX4    = 15;

  logic          clk = 1'b0;
  logic          rst_n, clear, data_valid;
  logic [DW-1:0] data_in;
  logic          locked, error, locked_s, error_s;
  logic [31:0]   err_count, word_count;
  logic [3:0]    err_count_s, word_count_s;

  always #5 clk = ~clk;

  lfsr_prbs_check #(
    .LFSR_WIDTH(W), .LFSR_POLY(POLY), .REVERSE(0), .DATA_WIDTH(DW),
    .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN), .ERR_COUNT_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in),
    .data_valid(data_valid), .locked(locked), .error(error),
    .err_count(err_count), .word_count(word_count)
  );

  lfsr_prbs_check #(
    .LFSR_WIDTH(W), .LFSR_POLY(POLY), .REVERSE(0), .DATA_WIDTH(DW),
    .LOCK_COUNT(LOCKN), .UNLOCK_COUNT(UNLOCKN), .ERR_COUNT_WIDTH(4)
  ) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .data_in(data_in),
    .data_valid(data_valid), .locked(locked_s), .error(error_s),
    .err_count(err_count_s), .word_count(word_count_s)
  );

  int total = 0;
  int bad   = 0;

  // Source and reference histories: last W bits of the sequence, oldest first.
  bit gen_hist[$];
  bit ref_hist[$];
  int     m_locked, m_fill, m_good, m_bad;
  bit     m_error;
  longint m_ec, m_wc, m_ec4, m_wc4;

  typedef struct {
    bit          vld;
    bit          clr;
    logic [7:0]  mask;
    bit          e_locked;
    bit          e_error;
    int          e_ec;
    int          e_wc;
  } vec_t;
  vec_t tbl[$];

  // Sequence rule: b[n] = XOR over k with POLY[k] of b[n-W+k].
  function automatic bit next_bit(input bit h[$]);
    bit b;
    b = 1'b0;
    for (int k = 0; k < W; k++) if (POLY[k]) b ^= h[h.size() - W + k];
    return b;
  endfunction

  task automatic gen_word(output logic [DW-1:0] w);
    bit b;
    w = '0;
    for (int i = 0; i < DW; i++) begin
      b = next_bit(gen_hist);
      gen_hist.push_back(b);
      void'(gen_hist.pop_front());
      w[DW-1-i] = b;
    end
  endtask

  task automatic model_reset();
    ref_hist.delete();
    for (int i = 0; i < W; i++) ref_hist.push_back(1'b1);
    m_locked = 0; m_fill = 0; m_good = 0; m_bad = 0; m_error = 0;
    m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0;
  endtask

  task automatic model_clock(input bit rstn, input bit clr, input bit vld, input logic [DW-1:0] d);
    bit            tmp[$];
    logic [DW-1:0] p;
    bit            zero_seed, b;
    int            n;
    if (!rstn) begin
      model_reset();
      return;
    end
    m_error = 1'b0;
    if (vld) begin
      tmp = ref_hist;
      p = '0;
      zero_seed = 1'b1;
      foreach (ref_hist[k]) if (ref_hist[k]) zero_seed = 1'b0;
      for (int i = 0; i < DW; i++) begin
        b = next_bit(tmp);
        tmp.push_back(b);
        p[DW-1-i] = b;
      end
      n = $countones(d ^ p);
      if (m_locked == 0) begin
        if (m_fill < FILLN) m_fill++;
        else begin
          if (n == 0 && !zero_seed) m_good++; else m_good = 0;
          if (m_good == LOCKN) begin m_locked = 1; m_good = 0; m_bad = 0; end
        end
        for (int i = 0; i < DW; i++) begin
          ref_hist.push_back(d[DW-1-i]);
          void'(ref_hist.pop_front());
        end
      end else begin
        m_wc  = (m_wc  + 1 > MAX32) ? MAX32 : m_wc + 1;
        m_wc4 = (m_wc4 + 1 > MAX4)  ? MAX4  : m_wc4 + 1;
        m_ec  = (m_ec  + n > MAX32) ? MAX32 : m_ec + n;
        m_ec4 = (m_ec4 + n > MAX4)  ? MAX4  : m_ec4 + n;
        m_error = (n != 0);
        if (n != 0) m_bad++; else m_bad = 0;
        if (m_bad == UNLOCKN) begin m_locked = 0; m_fill = 0; m_good = 0; m_bad = 0; end
        while (tmp.size() > W) void'(tmp.pop_front());
        ref_hist = tmp;
      end
    end
    if (clr) begin m_ec = 0; m_wc = 0; m_ec4 = 0; m_wc4 = 0; end
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rstn, input bit clr, input bit vld, input logic [DW-1:0] d);
    rst_n = rstn; clear = clr; data_valid = vld; data_in = d;
    @(posedge clk);
    model_clock(rstn, clr, vld, d);
    #1;
    chk("locked",       locked,       m_locked);
    chk("error",        error,        m_error);
    chk("err_count",    err_count,    m_ec);
    chk("word_count",   word_count,   m_wc);
    chk("locked_s",     locked_s,     m_locked);
    chk("error_s",      error_s,      m_error);
    chk("err_count_s",  err_count_s,  m_ec4);
    chk("word_count_s", word_count_s, m_wc4);
  endtask

  // One cycle with the source: a valid word is the next source word XOR mask.
  task automatic send(input bit clr, input bit vld, input logic [DW-1:0] mask);
    logic [DW-1:0] w;
    if (vld) begin
      gen_word(w);
      w = w ^ mask;
    end else begin
      w = DW'($urandom);
    end
    step(1'b1, clr, vld, w);
  endtask

  task automatic add(input bit v, input bit c, input logic [7:0] m,
                     input bit l, input bit e, input int ec, input int wc);
    vec_t t;
    t.vld = v; t.clr = c; t.mask = m; t.e_locked = l; t.e_error = e; t.e_ec = ec; t.e_wc = wc;
    tbl.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int burst;
    bit v, c;
    logic [7:0] mk;

    // Hand-derived expectations: lock, single-bit error, clear, unlock, relock,
    // valid gaps, and an unlock from a bad run spread around a good word.
    for (int i = 0; i < 7; i++) add(1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0, 1);
    add(1, 0, 8'h08, 1, 1, 1, 2);
    add(1, 0, 8'h00, 1, 0, 1, 3);
    add(0, 1, 8'h00, 1, 0, 0, 0);
    add(1, 0, 8'hFF, 1, 1, 8, 1);
    add(1, 0, 8'hFF, 1, 1, 16, 2);
    add(1, 0, 8'hFF, 1, 1, 24, 3);
    add(1, 0, 8'hFF, 0, 1, 32, 4);
    for (int i = 0; i < 7; i++) add(1, 0, 8'h00, 0, 0, 32, 4);
    add(1, 0, 8'h00, 1, 0, 32, 4);
    add(1, 0, 8'h01, 1, 1, 33, 5);
    add(0, 0, 8'h00, 1, 0, 33, 5);
    add(1, 0, 8'h01, 1, 1, 34, 6);
    add(1, 0, 8'h01, 1, 1, 35, 7);
    add(0, 0, 8'h00, 1, 0, 35, 7);
    add(1, 0, 8'h00, 1, 0, 35, 8);
    add(1, 0, 8'h01, 1, 1, 36, 9);
    add(1, 0, 8'h01, 1, 1, 37, 10);
    add(1, 0, 8'h01, 1, 1, 38, 11);
    add(1, 0, 8'h01, 0, 1, 39, 12);

    gen_hist.delete();
    for (int i = 0; i < W; i++) gen_hist.push_back(bit'($urandom_range(0, 1)));
    gen_hist[0] = 1'b1;

    // Reset state
    step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b0, '0);
    chk("rst_locked", locked, 0);
    chk("rst_error", error, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_word_count", word_count, 0);

    // Table-driven directed vectors
    for (int r = 0; r < tbl.size(); r++) begin
      send(tbl[r].clr, tbl[r].vld, tbl[r].mask);
      chk($sformatf("row%0d_locked", r), locked, tbl[r].e_locked);
      chk($sformatf("row%0d_error", r), error, tbl[r].e_error);
      chk($sformatf("row%0d_err_count", r), err_count, tbl[r].e_ec);
      chk($sformatf("row%0d_word_count", r), word_count, tbl[r].e_wc);
    end

    // Saturation of the 4-bit counters, then clear while locked
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 8; i++) send(1'b0, 1'b1, 8'h00);
    chk("sat_pre_locked", locked_s, 1);
    send(1'b0, 1'b1, 8'hFF);
    send(1'b0, 1'b1, 8'hFF);
    chk("sat_err_count_s", err_count_s, 15);
    chk("sat_err_count", err_count, 16);
    chk("sat_locked_s", locked_s, 1);
    send(1'b1, 1'b0, 8'h00);
    chk("clr_err_count_s", err_count_s, 0);
    chk("clr_word_count_s", word_count_s, 0);
    chk("clr_locked_s", locked_s, 1);
    send(1'b0, 1'b1, 8'h00);

    // Reset mid-lock together with clear and a valid word
    chk("pre_rst_locked", locked, 1);
    gen_word(data_in);
    step(1'b0, 1'b1, 1'b1, data_in);
    chk("midrst_locked", locked, 0);
    chk("midrst_err_count", err_count, 0);
    chk("midrst_word_count", word_count, 0);
    for (int i = 0; i < 7; i++) send(1'b0, 1'b1, 8'h00);
    chk("rehunt_7_locked", locked, 0);
    send(1'b0, 1'b1, 8'h00);
    chk("rehunt_8_locked", locked, 1);

    // All-zero input never locks
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      chk("zeros_locked", locked, 0);
    end

    // Randomized traffic against the reference model
    burst = 0;
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 59) == 0);
      if (burst == 0 && $urandom_range(0, 149) == 0) burst = $urandom_range(3, 6);
      if (burst > 0) begin
        mk = 8'($urandom_range(1, 255));
        if (v) burst--;
      end else if ($urandom_range(0, 99) < 8) begin
        mk = 8'(1 << $urandom_range(0, 7));
      end else begin
        mk = 8'h00;
      end
      if ($urandom_range(0, 499) == 0) step(1'b0, c, v, DW'($urandom));
      else send(c, v, mk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
